// File: rtl/vth_read_detector.sv
// vth_read_detector: quantise read voltages to MLC levels, align with written levels, count frame errors
//
// Ports:
//   clk, reset (sync, active-low)
//   level_in/level_valid : written level pushed into the alignment FIFO
//   vth_in/vth_valid     : post-retention voltage; each valid pops one written level
//   ref_v1..ref_v3       : read reference voltages
//   start                : clears counters and sticky flags, begins a frame
//   det_valid/det_level/det_written/sym_err : one-cycle-latency detection result
//   busy/done            : frame in progress / frame complete
//   total_cnt/sym_err_cnt/bit_err_cnt : saturating frame statistics
//   ovf/unf              : sticky FIFO overflow / underflow
module vth_read_detector #(
    parameter int VW        = 16,
    parameter int DEPTH     = 32,
    parameter int FRAME_LEN = 327648
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    level_in,
    input  logic          level_valid,
    input  logic [VW-1:0] vth_in,
    input  logic          vth_valid,
    input  logic [VW-1:0] ref_v1,
    input  logic [VW-1:0] ref_v2,
    input  logic [VW-1:0] ref_v3,
    input  logic          start,
    output logic          det_valid,
    output logic [1:0]    det_level,
    output logic [1:0]    det_written,
    output logic          sym_err,
    output logic          busy,
    output logic          done,
    output logic [31:0]   total_cnt,
    output logic [31:0]   sym_err_cnt,
    output logic [31:0]   bit_err_cnt,
    output logic          ovf,
    output logic          unf
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, next_state;
    logic [1:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          empty, full, pop, push, count_en;
    logic [1:0]    q, head, gx, bit_err;
    logic [31:0]   total_next;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [1:0] b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? '1 : s[31:0];
    endfunction

    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));
    assign pop   = vth_valid & ~empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign push  = level_valid & (~full | pop);
    assign head  = mem[rd_ptr];
    // Thermometer count stays meaningful even when the references are unordered.
    assign q     = 2'(vth_in >= ref_v1) + 2'(vth_in >= ref_v2) + 2'(vth_in >= ref_v3);
    assign gx    = (q ^ (q >> 1)) ^ (head ^ (head >> 1));
    assign bit_err = 2'(gx[1]) + 2'(gx[0]);
    // A detection coinciding with start is not counted: start clears instead.
    assign count_en   = pop & (state == RUN) & ~start;
    assign total_next = sat_add(total_cnt, 2'd1);

    always_ff @(posedge clk) begin
        if (!reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = start ? RUN
                   : (count_en && total_next == 32'(FRAME_LEN)) ? DONE
                   : state;
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= level_in;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            det_valid   <= 1'b0;
            det_level   <= '0;
            det_written <= '0;
            sym_err     <= 1'b0;
        end else begin
            det_valid <= pop;
            if (pop) begin
                det_level   <= q;
                det_written <= head;
                sym_err     <= (q != head);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || start) begin
            total_cnt   <= '0;
            sym_err_cnt <= '0;
            bit_err_cnt <= '0;
        end else if (count_en) begin
            total_cnt   <= total_next;
            sym_err_cnt <= sat_add(sym_err_cnt, 2'(q != head));
            bit_err_cnt <= sat_add(bit_err_cnt, bit_err);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset || start) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (level_valid && full && !pop)
                ovf <= 1'b1;
            if (vth_valid && empty)
                unf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vth_read_detector.sv
// tb_vth_read_detector: directed and randomized checks against a queue-based reference model
module tb_vth_read_detector;
    localparam int VW = 16;
    localparam int DEPTH = 32;
    localparam int FRAME_LEN = 4;

    logic          clk = 0;
    logic          reset, level_valid, vth_valid, start;
    logic [1:0]    level_in;
    logic [VW-1:0] vth_in, ref_v1, ref_v2, ref_v3;
    logic          det_valid, sym_err, busy, done, ovf, unf;
    logic [1:0]    det_level, det_written;
    logic [31:0]   total_cnt, sym_err_cnt, bit_err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vth_read_detector #(.VW(VW), .DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk(clk), .reset(reset), .level_in(level_in), .level_valid(level_valid),
        .vth_in(vth_in), .vth_valid(vth_valid), .ref_v1(ref_v1), .ref_v2(ref_v2),
        .ref_v3(ref_v3), .start(start), .det_valid(det_valid), .det_level(det_level),
        .det_written(det_written), .sym_err(sym_err), .busy(busy), .done(done),
        .total_cnt(total_cnt), .sym_err_cnt(sym_err_cnt), .bit_err_cnt(bit_err_cnt),
        .ovf(ovf), .unf(unf)
    );

    // Reference model state
    int          fifo[$];
    int          mode;
    bit          e_dv, e_se, e_ovf, e_unf;
    int          e_dl, e_dw;
    logic [31:0] e_tot, e_sym, e_bit;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] a, input int b);
        longint s;
        s = longint'(a) + b;
        return (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(s);
    endfunction

    task automatic cycle(input bit rst_n, input bit lv, input int lvl, input bit vv,
                         input int v, input bit st);
        int d, w;
        reset = rst_n; level_valid = lv; level_in = 2'(lvl);
        vth_valid = vv; vth_in = VW'(v); start = st;
        @(posedge clk);
        e_dv = 0;
        if (!rst_n) begin
            fifo.delete(); mode = 0; e_dl = 0; e_dw = 0; e_se = 0;
            e_ovf = 0; e_unf = 0; e_tot = 0; e_sym = 0; e_bit = 0;
        end else begin
            if (vv && fifo.size() == 0) e_unf = 1;
            if (vv && fifo.size() > 0) begin
                w = fifo.pop_front();
                d = int'(v >= int'(ref_v1)) + int'(v >= int'(ref_v2)) + int'(v >= int'(ref_v3));
                e_dv = 1; e_dl = d; e_dw = w; e_se = (d != w);
            end
            if (lv) begin
                if (fifo.size() < DEPTH) fifo.push_back(lvl);
                else e_ovf = 1;
            end
            if (st) begin
                mode = 1; e_tot = 0; e_sym = 0; e_bit = 0; e_ovf = 0; e_unf = 0;
            end else if (mode == 1 && e_dv) begin
                e_tot = sat(e_tot, 1);
                e_sym = sat(e_sym, int'(e_se));
                e_bit = sat(e_bit, $countones((e_dl ^ (e_dl >> 1)) ^ (e_dw ^ (e_dw >> 1))));
                if (e_tot == FRAME_LEN) mode = 2;
            end
        end
        #1;
        chk("det_valid", 32'(det_valid), 32'(e_dv));
        if (e_dv || !rst_n) begin
            chk("det_level", 32'(det_level), 32'(e_dl));
            chk("det_written", 32'(det_written), 32'(e_dw));
            chk("sym_err", 32'(sym_err), 32'(e_se));
        end
        chk("busy", 32'(busy), 32'(mode == 1));
        chk("done", 32'(done), 32'(mode == 2));
        chk("total_cnt", total_cnt, e_tot);
        chk("sym_err_cnt", sym_err_cnt, e_sym);
        chk("bit_err_cnt", bit_err_cnt, e_bit);
        chk("ovf", 32'(ovf), 32'(e_ovf));
        chk("unf", 32'(unf), 32'(e_unf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int vs[4];
        vs = '{999, 1000, 2500, 65535};
        ref_v1 = 1000; ref_v2 = 2000; ref_v3 = 3000;
        reset = 0; level_valid = 0; level_in = 0; vth_valid = 0; vth_in = 0; start = 0;
        @(negedge clk);
        // Pushes during reset must not enter the FIFO
        for (int i = 0; i < 3; i++) cycle(0, 1, i, 0, 0, 0);
        cycle(1, 0, 0, 1, 500, 0);
        // Quantiser boundaries, IDLE emits but does not count
        cycle(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 1, i, 0, 0, 0);
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 1, vs[i], 0);
        // Frame of 4: written 0 read 2, fifth detection not counted
        cycle(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 1, 2500, 0);
        // Single-bit Gray errors
        cycle(1, 0, 0, 0, 0, 1);
        cycle(1, 1, 1, 0, 0, 0);
        cycle(1, 1, 0, 1, 2500, 0);
        cycle(1, 0, 0, 1, 1500, 0);
        // Overflow: DEPTH+1 pushes, drain in order, then underflow
        for (int i = 0; i <= DEPTH; i++) cycle(1, 1, i % 4, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 1, 500 + 1000 * (i % 4), 0);
        cycle(1, 0, 0, 1, 0, 0);
        // Full FIFO with simultaneous push+pop keeps order and no overflow
        cycle(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, (i * 3) % 4, 0, 0, 0);
        for (int i = 0; i < 10; i++) cycle(1, 1, i % 4, 1, 1000 * (i % 4), 0);
        cycle(1, 1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) cycle(1, 0, 0, 1, 2000, 0);
        // Reset mid-frame
        cycle(1, 0, 0, 0, 0, 1);
        cycle(1, 1, 3, 0, 0, 0);
        cycle(1, 1, 2, 1, 3000, 0);
        cycle(0, 1, 2, 1, 3000, 0);
        idle(2);
        // Randomized traffic with unordered references and boundary-hitting voltages
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                ref_v1 = VW'($urandom_range(0, 4) * 1000);
                ref_v2 = VW'($urandom_range(0, 4) * 1000);
                ref_v3 = VW'($urandom_range(0, 4) * 1000);
            end
            cycle($urandom_range(0, 299) != 0, $urandom_range(0, 99) < 55,
                  int'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < 50,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535))
                                              : int'($urandom_range(0, 8)) * 500,
                  $urandom_range(0, 39) == 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
